// File: rtl/dump_ctrl_if.sv
// Signal bundle between dump_ctrl and its neighbours: cmd_cfg, the capture RAMs and the UART transmitter.
// Handshake: the controller pulses trmt for one cycle with tx_data stable. The transmitter answers with tx_done,
// which is honoured only while the controller is waiting for it. ren is a one-cycle read strobe, and rdata is valid one clock later.
interface dump_ctrl_if #(
  parameter int LOG2 = 9
);
  logic            dump;
  logic [2:0]      ch_sel;
  logic            capture_done;
  logic [LOG2-1:0] waddr;
  logic [LOG2-1:0] raddr;
  logic            ren;
  logic [2:0]      rd_ch;
  logic [7:0]      rdata;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            tx_done;
  logic            busy;
  logic            dump_done;
  logic            dump_err;
  logic            clr_capture_done;

  modport master (
    input  dump, ch_sel, capture_done, waddr, rdata, tx_done,
    output raddr, ren, rd_ch, tx_data, trmt, busy, dump_done, dump_err, clr_capture_done
  );

  modport slave (
    output dump, ch_sel, capture_done, waddr, rdata, tx_done,
    input  raddr, ren, rd_ch, tx_data, trmt, busy, dump_done, dump_err, clr_capture_done
  );
endinterface

// File: rtl/dump_ctrl.sv
// Reads the circular capture RAM oldest-sample-first after a capture and sends one byte per UART handshake.
// The FSM state is exposed on dbg_state_o.
module dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  dump_ctrl_if.master bus,
  output logic [2:0] dbg_state_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] SEND    = 3'd3;
  localparam logic [2:0] WAIT_TX = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  // Wrap point is the real RAM depth, which need not be a power of two.
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] ONE  = LOG2'(1);

  logic [2:0]      state_q, state_d;
  logic [LOG2-1:0] raddr_q, raddr_d;
  logic [LOG2-1:0] cnt_q, cnt_d;
  logic [2:0]      rd_ch_q, rd_ch_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            dump_err_q, dump_err_d;

  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    cnt_d      = cnt_q;
    rd_ch_d    = rd_ch_q;
    tx_data_d  = tx_data_q;
    dump_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dump) begin
          if (bus.capture_done) begin
            raddr_d = bus.waddr;
            rd_ch_d = bus.ch_sel;
            cnt_d   = '0;
            state_d = READ;
          end else begin
            dump_err_d = 1'b1;
          end
        end
      end
      READ:    state_d = LOAD;
      LOAD: begin
        tx_data_d = bus.rdata;
        state_d   = SEND;
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (bus.tx_done) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + ONE;
            raddr_d = (raddr_q == LAST) ? '0 : raddr_q + ONE;
            state_d = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      raddr_q    <= '0;
      cnt_q      <= '0;
      rd_ch_q    <= '0;
      tx_data_q  <= '0;
      dump_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      cnt_q      <= cnt_d;
      rd_ch_q    <= rd_ch_d;
      tx_data_q  <= tx_data_d;
      dump_err_q <= dump_err_d;
    end
  end

  // Strobes decode straight from the state register, so a reset clears them with no extra cycle.
  assign bus.raddr            = raddr_q;
  assign bus.rd_ch            = rd_ch_q;
  assign bus.tx_data          = tx_data_q;
  assign bus.ren              = (state_q == READ);
  assign bus.trmt             = (state_q == SEND);
  assign bus.busy             = (state_q != IDLE);
  assign bus.dump_done        = (state_q == DONE);
  assign bus.clr_capture_done = (state_q == DONE);
  assign bus.dump_err         = dump_err_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_dump_ctrl.sv
// Directed bench for dump_ctrl: RAM model, automatic UART responder, byte scoreboard and a linear step sequence.
module tb_dump_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dump_ctrl_if #(.LOG2(LOG2)) bus ();
  logic [2:0] dbg_state;

  dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel 2 holds RAM[i]=i[7:0]; other channels are XOR-tagged so a wrong rd_ch shows up.
  function automatic logic [7:0] ram_val(input logic [2:0] c, input int i);
    logic [7:0] k;
    k = (8'(c) ^ 8'd2) * 8'h11;
    return 8'(i) ^ k;
  endfunction

  always @(posedge clk) begin
    if (bus.ren) bus.rdata <= ram_val(bus.rd_ch, int'(bus.raddr));
  end

  // UART responder: tx_done five cycles after each trmt while auto_tx is set.
  logic auto_tx = 1'b0;
  logic tx_auto = 1'b0;
  logic tx_man  = 1'b0;
  int   tdly    = 0;
  assign bus.tx_done = auto_tx ? tx_auto : tx_man;

  always @(negedge clk) begin
    tx_auto = 1'b0;
    if (!rst_n || !auto_tx) tdly = 0;
    else if (bus.trmt) tdly = 5;
    else if (tdly > 0) begin
      tdly--;
      if (tdly == 0) tx_auto = 1'b1;
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int trmt_cnt = 0;
  int done_cnt = 0;
  int clr_cnt  = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (bus.ren) check("raddr_range", 32'(32'(bus.raddr) < ENTRIES), 32'd1);
    if (bus.trmt) begin
      trmt_cnt++;
      check("tx_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("tx_data_seq", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    end
    if (bus.dump_done)        done_cnt++;
    if (bus.clr_capture_done) clr_cnt++;
    if (bus.dump_err)         err_cnt++;
  end

  // driver tasks
  task automatic push_dump(input logic [2:0] ch, input int start);
    for (int k = 0; k < ENTRIES; k++) exp_q.push_back(ram_val(ch, (start + k) % ENTRIES));
  endtask

  task automatic wait_bytes(input int target, input string tag);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      #1;
      if (trmt_cnt >= target) break;
    end
    check(tag, 32'(trmt_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.dump_done) break;
    end
    check({tag, "_done_seen"}, 32'(bus.dump_done), 32'd1);
    check({tag, "_clr_with_done"}, 32'(bus.clr_capture_done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_done_one_cycle"}, 32'(bus.dump_done), 32'd0);
  endtask

  int base, done_base, clr_base, err_base;

  initial begin
    bus.dump = 1'b0; bus.ch_sel = 3'd0; bus.capture_done = 1'b0; bus.waddr = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_raddr",   32'(bus.raddr), 32'd0);
    check("rst_ren",     32'(bus.ren), 32'd0);
    check("rst_rd_ch",   32'(bus.rd_ch), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_trmt",    32'(bus.trmt), 32'd0);
    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_done",    32'(bus.dump_done), 32'd0);
    check("rst_err",     32'(bus.dump_err), 32'd0);
    check("rst_clr",     32'(bus.clr_capture_done), 32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // dump refused without capture_done
    bus.dump = 1'b1; bus.capture_done = 1'b0; bus.ch_sel = 3'd3;
    @(negedge clk);
    bus.dump = 1'b0;
    check("err_pulse", 32'(bus.dump_err), 32'd1);
    check("err_busy",  32'(bus.busy), 32'd0);
    check("err_ren",   32'(bus.ren), 32'd0);
    @(negedge clk);
    check("err_one_cycle", 32'(bus.dump_err), 32'd0);
    check("err_no_busy",   32'(bus.busy), 32'd0);
    check("err_no_ren",    32'(bus.ren), 32'd0);
    check("err_no_trmt",   32'(bus.trmt), 32'd0);

    // dump A: waddr=380 wraps, first-byte timing, ignored tx_done in LOAD, mid-dump disturbances
    base = trmt_cnt; done_base = done_cnt; clr_base = clr_cnt; err_base = err_cnt;
    push_dump(3'd2, 380);
    bus.waddr = 9'd380; bus.ch_sel = 3'd2; bus.capture_done = 1'b1; bus.dump = 1'b1;
    #1 check("a_ren_dump_cycle", 32'(bus.ren), 32'd0);
    @(negedge clk);
    bus.dump = 1'b0;
    check("a_ren_n1",      32'(bus.ren), 32'd1);
    check("a_raddr_first", 32'(bus.raddr), 32'd380);
    check("a_rd_ch",       32'(bus.rd_ch), 32'd2);
    check("a_busy",        32'(bus.busy), 32'd1);
    @(negedge clk);
    check("a_load_ren",  32'(bus.ren), 32'd0);
    check("a_load_trmt", 32'(bus.trmt), 32'd0);
    tx_man = 1'b1;
    @(negedge clk);
    tx_man = 1'b0;
    check("a_trmt_n3",   32'(bus.trmt), 32'd1);
    check("a_tx_data0",  32'(bus.tx_data), 32'h7C);
    repeat (3) @(negedge clk);
    check("a_hold_ren",   32'(bus.ren), 32'd0);
    check("a_hold_state", 32'(dbg_state), 32'd4);
    tx_man = 1'b1;
    @(negedge clk);
    tx_man = 1'b0;
    check("a_next_ren",   32'(bus.ren), 32'd1);
    check("a_next_raddr", 32'(bus.raddr), 32'd381);
    auto_tx = 1'b1;
    wait_bytes(base + 20, "a_reach20");
    bus.waddr = 9'd17; bus.ch_sel = 3'd4; bus.dump = 1'b1;
    @(negedge clk);
    bus.dump = 1'b0; bus.capture_done = 1'b0;
    check("a_busy_mid", 32'(bus.busy), 32'd1);
    wait_done("a");
    check("a_bytes",    32'(trmt_cnt - base), 32'd384);
    check("a_q_empty",  32'(exp_q.size()), 32'd0);
    check("a_done_cnt", 32'(done_cnt - done_base), 32'd1);
    check("a_clr_cnt",  32'(clr_cnt - clr_base), 32'd1);
    check("a_no_err",   32'(err_cnt - err_base), 32'd0);
    check("a_tx_hold",  32'(bus.tx_data), 32'h7B);

    // dump B: waddr=0, data 0..255,0..127
    base = trmt_cnt; done_base = done_cnt;
    push_dump(3'd2, 0);
    bus.waddr = 9'd0; bus.ch_sel = 3'd2; bus.capture_done = 1'b1; bus.dump = 1'b1;
    @(negedge clk);
    bus.dump = 1'b0;
    check("b_raddr_first", 32'(bus.raddr), 32'd0);
    wait_done("b");
    check("b_bytes",    32'(trmt_cnt - base), 32'd384);
    check("b_q_empty",  32'(exp_q.size()), 32'd0);
    check("b_done_cnt", 32'(done_cnt - done_base), 32'd1);
    check("b_tx_hold",  32'(bus.tx_data), 32'h7F);

    // dump C: reset after the 100th byte, then restart from a new waddr
    base = trmt_cnt; done_base = done_cnt; clr_base = clr_cnt;
    push_dump(3'd1, 100);
    bus.waddr = 9'd100; bus.ch_sel = 3'd1; bus.dump = 1'b1;
    @(negedge clk);
    bus.dump = 1'b0;
    wait_bytes(base + 100, "c_reach100");
    rst_n = 1'b0;
    #1;
    check("c_rst_busy",  32'(bus.busy), 32'd0);
    check("c_rst_trmt",  32'(bus.trmt), 32'd0);
    check("c_rst_ren",   32'(bus.ren), 32'd0);
    check("c_rst_done",  32'(bus.dump_done), 32'd0);
    check("c_rst_raddr", 32'(bus.raddr), 32'd0);
    check("c_rst_tx",    32'(bus.tx_data), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    check("c_no_done", 32'(done_cnt - done_base), 32'd0);
    check("c_no_clr",  32'(clr_cnt - clr_base), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    base = trmt_cnt; done_base = done_cnt;
    push_dump(3'd3, 200);
    bus.waddr = 9'd200; bus.ch_sel = 3'd3; bus.capture_done = 1'b1; bus.dump = 1'b1;
    @(negedge clk);
    bus.dump = 1'b0;
    check("c_new_ren",   32'(bus.ren), 32'd1);
    check("c_new_raddr", 32'(bus.raddr), 32'd200);
    check("c_new_rd_ch", 32'(bus.rd_ch), 32'd3);
    wait_done("c");
    check("c_bytes",    32'(trmt_cnt - base), 32'd384);
    check("c_q_empty",  32'(exp_q.size()), 32'd0);
    check("c_done_cnt", 32'(done_cnt - done_base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dump_ctrl.md
Name: dump_ctrl

Overview:
- Reads out the circular capture RAM after a capture completes, oldest sample first, one byte per transmit handshake.
- Sits between cmd_cfg (dump command, channel select) and the capture RAMs / UART transmitter.
- Takes the current write address from the capture block as the oldest-sample pointer.
- Clears capture_done in cmd_cfg when the dump finishes so the next run can start.

Parameters:
ENTRIES, 384, RAM depth in samples (384 for simulation, 12288 for DE-0)
LOG2, 9, address width; ENTRIES <= 2**LOG2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
dump  input  1  one-cycle dump request from cmd_cfg
ch_sel  input  3  RAM/channel to dump (0-4), sampled with dump
capture_done  input  1  capture complete flag from cmd_cfg
waddr  input  LOG2  capture write pointer (next location to be written = oldest sample)
raddr  output  LOG2  RAM read address
ren  output  1  RAM read enable; data valid on rdata one clock later
rd_ch  output  3  latched channel select steering the RAM read mux
rdata  input  8  RAM read data
tx_data  output  8  byte to UART transmitter
trmt  output  1  one-cycle transmit strobe
tx_done  input  1  transmitter finished current byte
busy  output  1  dump in progress
dump_done  output  1  one-cycle pulse, dump complete
dump_err  output  1  one-cycle pulse, dump requested with capture_done=0
clr_capture_done  output  1  one-cycle pulse to clear capture_done in cmd_cfg

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counter cnt = 0.
- States: IDLE, READ, LOAD, SEND, WAIT_TX, DONE.
- IDLE:
  - dump & capture_done: latch raddr <= waddr, rd_ch <= ch_sel, cnt <= 0, busy <= 1, go to READ.
  - dump & !capture_done: dump_err=1 for 1 cycle, stay IDLE, no RAM access.
- READ: ren=1 for exactly this cycle at raddr; go to LOAD.
- LOAD: tx_data <= rdata (registered); go to SEND.
- SEND: trmt=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: hold until tx_done=1. tx_done asserted during READ/LOAD/SEND is ignored. Then:
  - cnt == ENTRIES-1: go to DONE.
  - Otherwise: cnt <= cnt+1; raddr <= (raddr == ENTRIES-1) ? 0 : raddr+1; go to READ.
- DONE: dump_done=1 and clr_capture_done=1 for one cycle; busy <= 0; go to IDLE.
- Latency: dump to first ren = 1 cycle; ren to trmt = 2 cycles; tx_done to next ren = 1 cycle.
- Exactly ENTRIES bytes are sent per dump, in address order starting at the latched waddr and wrapping ENTRIES-1 -> 0, never touching addresses >= ENTRIES.
- waddr, ch_sel and capture_done changes after the dump is accepted are ignored. capture_done dropping mid-dump does not abort.
- dump while busy is ignored: no restart, no error.
- busy = 1 from the cycle after dump is accepted through the DONE cycle inclusive.
- tx_data holds its last value between bytes and after DONE.
- Asynchronous reset mid-dump returns to IDLE immediately with all outputs 0. No dump_done or clr_capture_done is issued.
- raddr/cnt arithmetic is LOG2 bits; the wrap compare is against ENTRIES-1, not 2**LOG2-1.

Test Plan:
- Fill RAM[i]=i[7:0], waddr=0, capture_done=1, ch_sel=2, dump, tx_done returned 5 cycles after each trmt -> 384 trmt pulses; tx_data sequence 0..255,0..127; rd_ch=2; exactly one dump_done and one clr_capture_done after the 384th tx_done.
- waddr=380, same data -> tx_data order is RAM[380..383], then RAM[0..379]; raddr never exceeds 383.
- dump with capture_done=0 -> dump_err pulses 1 cycle; ren, trmt and busy stay 0.
- Second dump and waddr change to 17 issued mid-dump -> ignored; sequence continues uninterrupted, total 384 bytes.
- Timing check on the first byte: dump at cycle N -> ren at N+1, trmt at N+3; tx_done at cycle M -> next ren at M+1. tx_done pulsed during LOAD -> no advance.
- Assert rst_n=0 after the 100th byte -> busy, trmt, ren and dump_done go 0 immediately; after release, a new dump restarts at the latched new waddr with cnt=0.
